// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-and-add unsigned multiplier: one shared ripple adder,
// one partial-product bit per cycle, with a start/busy/done handshake.
module shift_add_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [CW-1:0]      count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH:0]     carry;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;

    assign carry[0] = 1'b0;
    assign addend   = mq_q[0] ? mcand_q : '0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_Adder u_fa (
            .in1  (acc_q[i]),
            .in2  (addend[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = done_q;
        product_d = product_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d   = a;
                    acc_d     = '0;
                    mq_d      = b;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    product_d = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                // Carry-out becomes the new accumulator MSB on every shift.
                {acc_d, mq_d} = {carry[WIDTH], sum, mq_q[WIDTH-1:1]};
                count_d       = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    product_d = {carry[WIDTH], sum, mq_q[WIDTH-1:1]};
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// One-bit full adder cell used to build the shared ripple-carry adder.
module full_Adder (
    input  logic in1,
    input  logic in2,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = in1 ^ in2 ^ cin;
    assign cout = (in1 & in2) | (cin & (in1 ^ in2));

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: directed corner cases plus a long
// random back-to-back run, compared against a cycle-count product model.
module tb_shift_add_mult_ctrl;

    localparam int W = 8;
    localparam int RAND_CYCLES = 12000;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: operation age since acceptance and latched product.
    bit             m_run  = 1'b0;
    int             m_age  = 0;
    logic [2*W-1:0] m_pend = '0;
    logic [2*W-1:0] m_prod = '0;
    bit             m_done = 1'b0;
    int             m_accepts = 0;
    int             seen_dones = 0;

    shift_add_mult_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_run  = 1'b0;
            m_done = 1'b0;
            m_prod = '0;
        end else if (!m_run) begin
            m_done = 1'b0;
            if (start) begin
                m_run  = 1'b1;
                m_age  = 0;
                m_pend = (2*W)'(a) * (2*W)'(b);
                m_prod = '0;
                m_accepts++;
            end
        end else begin
            m_age++;
            m_done = (m_age == W);
            if (m_age == W) m_prod = m_pend;
            if (m_age == W + 1) m_run = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (done === 1'b1) seen_dones++;
        chk("busy", 32'(busy), 32'(m_run));
        chk("done", 32'(done), 32'(m_done));
        chk("product", 32'(product), 32'(m_prod));
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [2*W-1:0] want);
        a     = ia;
        b     = ib;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < W + 1; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            tick();
            if (i == W - 1) begin
                chk("done_at_latency", 32'(done), 32'd1);
                chk("const_product", 32'(product), 32'(want));
            end
        end
        chk("idle_after_op", 32'(busy), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("reset_product", 32'(product), 32'h0);

        run_op(8'h0D, 8'h0B, 16'h008F);
        run_op(8'hFF, 8'hFF, 16'hFE01);
        run_op(8'h00, 8'hFF, 16'h0000);
        run_op(8'h80, 8'h02, 16'h0100);
        run_op(8'hFF, 8'h01, 16'h00FF);

        // Operand isolation with start held through the whole operation.
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        tick();
        a = 8'hFF;
        b = 8'hFF;
        for (int i = 0; i < W + 1; i++) begin
            tick();
            if (i == W - 1) chk("iso_product", 32'(product), 32'h03A8);
        end
        tick();
        chk("iso_second_accept", 32'(busy), 32'd1);
        start = 1'b0;
        for (int i = 0; i < W + 1; i++) tick();
        chk("iso_second_product", 32'(product), 32'hFE01);

        // Reset in the 4th RUN cycle aborts the operation.
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_product", 32'(product), 32'h0);
        for (int i = 0; i < W + 2; i++) tick();
        run_op(8'h03, 8'h05, 16'h000F);

        // Reset wins over a simultaneous start.
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("rst_start_busy", 32'(busy), 32'd0);

        // Random operands, start held for maximum acceptance rate.
        start = 1'b1;
        for (int i = 0; i < RAND_CYCLES; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < W + 2; i++) tick();
        chk("done_count", 32'(seen_dones), 32'(m_accepts - 1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
